// File: rtl/bullet_collision.sv
// Bullet/alien and bullet/shield overlap detector.
// Issues one kill per frame and maintains the score.
module bullet_collision #(
  parameter int SCREEN_CORDW = 16,
  parameter int ALIEN_COLW   = 4,
  parameter int ALIEN_ROWW   = 3,
  parameter int SCORE_W      = 16,
  parameter int POINTS       = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame,
  input  logic                    game_active,
  input  logic [SCREEN_CORDW-1:0] screen_x,
  input  logic [SCREEN_CORDW-1:0] screen_y,
  input  logic                    bullet_drawing,
  input  logic                    alien_drawing,
  input  logic [ALIEN_COLW-1:0]   alien_col,
  input  logic [ALIEN_ROWW-1:0]   alien_row,
  input  logic                    shield_drawing,
  input  logic                    kill_ready,
  output logic                    kill_valid,
  output logic [ALIEN_COLW-1:0]   kill_col,
  output logic [ALIEN_ROWW-1:0]   kill_row,
  output logic [SCREEN_CORDW-1:0] hit_x,
  output logic [SCREEN_CORDW-1:0] hit_y,
  output logic                    bullet_rst,
  output logic [SCORE_W-1:0]      score
);

  localparam logic [1:0] SCAN   = 2'd0;
  localparam logic [1:0] REPORT = 2'd1;
  localparam logic [1:0] CLEAR  = 2'd2;

  localparam logic [SCORE_W:0] PTS = (SCORE_W+1)'(POINTS);

  logic [1:0]              r_state;
  logic                    r_alien_hit;
  logic                    r_shield_hit;
  logic                    r_kill_valid;
  logic [ALIEN_COLW-1:0]   r_kill_col;
  logic [ALIEN_ROWW-1:0]   r_kill_row;
  logic [SCREEN_CORDW-1:0] r_hit_x;
  logic [SCREEN_CORDW-1:0] r_hit_y;
  logic                    r_bullet_rst;
  logic [SCORE_W-1:0]      r_score;

  logic                    w_arm;
  logic [SCORE_W:0]        w_sum;
  logic [SCORE_W-1:0]      w_score_nxt;

  // only the first overlap in raster order is latched each frame
  assign w_arm = game_active & bullet_drawing &
                 ~r_alien_hit & ~r_shield_hit;

  assign w_sum       = {1'b0, r_score} + PTS;
  assign w_score_nxt = w_sum[SCORE_W] ? '1 : w_sum[SCORE_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= SCAN;
      r_alien_hit  <= 1'b0;
      r_shield_hit <= 1'b0;
      r_kill_valid <= 1'b0;
      r_kill_col   <= '0;
      r_kill_row   <= '0;
      r_hit_x      <= '0;
      r_hit_y      <= '0;
      r_bullet_rst <= 1'b0;
      r_score      <= '0;
    end else begin
      unique case (r_state)
        SCAN: begin
          if (frame) begin
            r_alien_hit  <= 1'b0;
            r_shield_hit <= 1'b0;
            if (r_alien_hit) begin
              r_state      <= REPORT;
              r_kill_valid <= 1'b1;
            end else if (r_shield_hit) begin
              r_state      <= CLEAR;
              r_bullet_rst <= 1'b1;
            end
          end else if (w_arm && alien_drawing) begin
            r_alien_hit <= 1'b1;
            r_kill_col  <= alien_col;
            r_kill_row  <= alien_row;
            r_hit_x     <= screen_x;
            r_hit_y     <= screen_y;
          end else if (w_arm && shield_drawing) begin
            r_shield_hit <= 1'b1;
            r_hit_x      <= screen_x;
            r_hit_y      <= screen_y;
          end
        end
        REPORT: begin
          if (kill_ready) begin
            r_kill_valid <= 1'b0;
            r_score      <= w_score_nxt;
            r_bullet_rst <= 1'b1;
            r_state      <= CLEAR;
          end
        end
        CLEAR: begin
          if (frame) begin
            r_bullet_rst <= 1'b0;
            r_state      <= SCAN;
          end
        end
        default: r_state <= SCAN;
      endcase
    end
  end

  assign kill_valid = r_kill_valid;
  assign kill_col   = r_kill_col;
  assign kill_row   = r_kill_row;
  assign hit_x      = r_hit_x;
  assign hit_y      = r_hit_y;
  assign bullet_rst = r_bullet_rst;
  assign score      = r_score;

endmodule

// File: tb/tb_bullet_collision.sv
// Directed vector bench for bullet_collision.
// A second instance with a 5-bit score tracks saturation.
module tb_bullet_collision;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame, game_active;
  logic [15:0] screen_x, screen_y;
  logic        bullet_drawing, alien_drawing, shield_drawing;
  logic [3:0]  alien_col;
  logic [2:0]  alien_row;
  logic        kill_ready;

  logic        kill_valid, bullet_rst;
  logic [3:0]  kill_col;
  logic [2:0]  kill_row;
  logic [15:0] hit_x, hit_y, score;

  logic        kv5, br5;
  logic [3:0]  kc5;
  logic [2:0]  kr5;
  logic [15:0] hx5, hy5;
  logic [4:0]  score5;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  bullet_collision u_dut (
    .clk(clk), .rst(rst), .frame(frame), .game_active(game_active),
    .screen_x(screen_x), .screen_y(screen_y),
    .bullet_drawing(bullet_drawing), .alien_drawing(alien_drawing),
    .alien_col(alien_col), .alien_row(alien_row),
    .shield_drawing(shield_drawing), .kill_ready(kill_ready),
    .kill_valid(kill_valid), .kill_col(kill_col), .kill_row(kill_row),
    .hit_x(hit_x), .hit_y(hit_y), .bullet_rst(bullet_rst),
    .score(score)
  );

  bullet_collision #(.SCORE_W(5), .POINTS(10)) u_dut5 (
    .clk(clk), .rst(rst), .frame(frame), .game_active(game_active),
    .screen_x(screen_x), .screen_y(screen_y),
    .bullet_drawing(bullet_drawing), .alien_drawing(alien_drawing),
    .alien_col(alien_col), .alien_row(alien_row),
    .shield_drawing(shield_drawing), .kill_ready(kill_ready),
    .kill_valid(kv5), .kill_col(kc5), .kill_row(kr5),
    .hit_x(hx5), .hit_y(hy5), .bullet_rst(br5),
    .score(score5)
  );

  typedef struct {
    logic        fr, act, bd, ad, sd;
    logic [3:0]  col;
    logic [2:0]  row;
    logic [15:0] x, y;
    logic        rdy;
    logic        ev, ebr, cf;
    logic [3:0]  ecol;
    logic [2:0]  erow;
    logic [15:0] ehx, ehy, esc;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    int fr, int act, int bd, int ad, int sd, int col, int row,
    int x, int y, int rdy, int ev, int ebr, int cf,
    int ecol, int erow, int ehx, int ehy, int esc);
    vec_t r;
    r.fr = fr[0];   r.act = act[0]; r.bd = bd[0];
    r.ad = ad[0];   r.sd = sd[0];
    r.col = col[3:0]; r.row = row[2:0];
    r.x = x[15:0];  r.y = y[15:0];  r.rdy = rdy[0];
    r.ev = ev[0];   r.ebr = ebr[0]; r.cf = cf[0];
    r.ecol = ecol[3:0]; r.erow = erow[2:0];
    r.ehx = ehx[15:0];  r.ehy = ehy[15:0];
    r.esc = esc[15:0];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    frame = v.fr; game_active = v.act;
    bullet_drawing = v.bd; alien_drawing = v.ad;
    shield_drawing = v.sd;
    alien_col = v.col; alien_row = v.row;
    screen_x = v.x; screen_y = v.y;
    kill_ready = v.rdy;
  endtask

  function automatic logic [31:0] sat5(input logic [15:0] s);
    return (s > 16'd31) ? 32'd31 : {16'd0, s};
  endfunction

  task automatic step(input vec_t v);
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t idle;
    idle = mk(0,1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0);
    rst = 1'b1;
    drive(idle);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, kill_valid}, 0);
    chk("rst_brst",  {31'd0, bullet_rst}, 0);
    chk("rst_score", {16'd0, score}, 0);
    chk("rst_col",   {28'd0, kill_col}, 0);
    chk("rst_row",   {29'd0, kill_row}, 0);
    chk("rst_hitx",  {16'd0, hit_x}, 0);
    chk("rst_hity",  {16'd0, hit_y}, 0);
    @(negedge clk);
    rst = 1'b0;

    // basic kill at (100,200) col 3 row 1
    tv.push_back(mk(0,1,1,1,0,3,1,100,200,0, 0,0,0,0,0,0,0,0));
    tv.push_back(mk(0,1,0,0,0,0,0,0,0,0,     0,0,0,0,0,0,0,0));
    tv.push_back(mk(1,1,0,0,0,0,0,0,0,1,     1,0,1,3,1,100,200,0));
    tv.push_back(mk(0,1,0,0,0,0,0,0,0,1,     0,1,0,0,0,0,0,10));
    tv.push_back(mk(0,1,0,0,0,0,0,0,0,0,     0,1,0,0,0,0,0,10));
    tv.push_back(mk(1,1,0,0,0,0,0,0,0,0,     0,0,0,0,0,0,0,10));
    // two overlaps in one frame: first wins
    tv.push_back(mk(0,1,1,1,0,2,0,50,60,0,   0,0,0,0,0,0,0,10));
    tv.push_back(mk(0,1,1,1,0,5,4,70,80,0,   0,0,0,0,0,0,0,10));
    tv.push_back(mk(1,1,0,0,0,0,0,0,0,0,     1,0,1,2,0,50,60,10));
    tv.push_back(mk(0,1,0,0,0,0,0,0,0,1,     0,1,0,0,0,0,0,20));
    tv.push_back(mk(1,1,0,0,0,0,0,0,0,0,     0,0,0,0,0,0,0,20));
    // shield-only hit at (40,300)
    tv.push_back(mk(0,1,1,0,1,0,0,40,300,0,  0,0,0,0,0,0,0,20));
    tv.push_back(mk(1,1,0,0,0,0,0,0,0,0,     0,1,0,0,0,0,0,20));
    tv.push_back(mk(0,1,0,0,0,0,0,0,0,0,     0,1,0,0,0,0,0,20));
    tv.push_back(mk(1,1,0,0,0,0,0,0,0,0,     0,0,0,0,0,0,0,20));
    // game inactive, then overlap on the frame cycle itself
    tv.push_back(mk(0,0,1,1,0,1,1,9,9,0,     0,0,0,0,0,0,0,20));
    tv.push_back(mk(1,1,1,1,0,6,6,3,3,0,     0,0,0,0,0,0,0,20));
    // alien over shield: alien wins
    tv.push_back(mk(0,1,1,1,1,7,2,5,6,0,     0,0,0,0,0,0,0,20));
    tv.push_back(mk(1,1,0,0,0,0,0,0,0,0,     1,0,1,7,2,5,6,20));
    // ready held low across three frames with overlaps
    tv.push_back(mk(1,1,1,1,0,9,3,1,1,0,     1,0,1,7,2,5,6,20));
    tv.push_back(mk(0,1,1,1,0,9,3,1,1,0,     1,0,1,7,2,5,6,20));
    tv.push_back(mk(1,1,0,0,0,0,0,0,0,0,     1,0,1,7,2,5,6,20));
    tv.push_back(mk(0,1,1,0,1,0,0,2,2,0,     1,0,1,7,2,5,6,20));
    tv.push_back(mk(1,1,0,0,0,0,0,0,0,0,     1,0,1,7,2,5,6,20));
    tv.push_back(mk(0,1,0,0,0,0,0,0,0,1,     0,1,0,0,0,0,0,30));
    tv.push_back(mk(0,1,0,0,0,0,0,0,0,1,     0,1,0,0,0,0,0,30));
    tv.push_back(mk(1,1,0,0,0,0,0,0,0,0,     0,0,0,0,0,0,0,30));
    // fourth kill saturates the 5-bit score
    tv.push_back(mk(0,1,1,1,0,15,7,639,479,0,0,0,0,0,0,0,0,30));
    tv.push_back(mk(1,1,0,0,0,0,0,0,0,0,     1,0,1,15,7,639,479,30));
    tv.push_back(mk(0,1,0,0,0,0,0,0,0,1,     0,1,0,0,0,0,0,40));
    tv.push_back(mk(1,1,0,0,0,0,0,0,0,0,     0,0,0,0,0,0,0,40));

    foreach (tv[i]) begin
      step(tv[i]);
      chk($sformatf("v%0d_valid", i), {31'd0, kill_valid}, {31'd0, tv[i].ev});
      chk($sformatf("v%0d_brst", i),  {31'd0, bullet_rst}, {31'd0, tv[i].ebr});
      chk($sformatf("v%0d_score", i), {16'd0, score}, {16'd0, tv[i].esc});
      chk($sformatf("v%0d_score5", i), {27'd0, score5}, sat5(tv[i].esc));
      if (tv[i].cf) begin
        chk($sformatf("v%0d_col", i),  {28'd0, kill_col}, {28'd0, tv[i].ecol});
        chk($sformatf("v%0d_row", i),  {29'd0, kill_row}, {29'd0, tv[i].erow});
        chk($sformatf("v%0d_hitx", i), {16'd0, hit_x}, {16'd0, tv[i].ehx});
        chk($sformatf("v%0d_hity", i), {16'd0, hit_y}, {16'd0, tv[i].ehy});
      end
    end

    // asynchronous reset while a kill is pending
    step(mk(0,1,1,1,0,4,2,11,22,0, 0,0,0,0,0,0,0,0));
    step(mk(1,1,0,0,0,0,0,0,0,0,   0,0,0,0,0,0,0,0));
    chk("pre_rst_valid", {31'd0, kill_valid}, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, kill_valid}, 0);
    chk("arst_brst",  {31'd0, bullet_rst}, 0);
    chk("arst_score", {16'd0, score}, 0);
    @(negedge clk);
    rst = 1'b0;
    step(mk(0,1,1,1,0,4,2,11,22,0, 0,0,0,0,0,0,0,0));
    chk("post_valid0", {31'd0, kill_valid}, 0);
    step(mk(1,1,0,0,0,0,0,0,0,0,   0,0,0,0,0,0,0,0));
    chk("post_valid", {31'd0, kill_valid}, 1);
    chk("post_col",   {28'd0, kill_col}, 4);
    chk("post_row",   {29'd0, kill_row}, 2);
    chk("post_hitx",  {16'd0, hit_x}, 11);
    chk("post_hity",  {16'd0, hit_y}, 22);
    step(mk(0,1,0,0,0,0,0,0,0,1,   0,0,0,0,0,0,0,0));
    chk("post_score",  {16'd0, score}, 10);
    chk("post_score5", {27'd0, score5}, 10);
    chk("post_brst",   {31'd0, bullet_rst}, 1);

    // reset mid-CLEAR drops bullet_rst at once
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("clr_rst_brst", {31'd0, bullet_rst}, 0);
    @(negedge clk);
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bullet_collision.md
Name: bullet_collision

Overview:
- Sits downstream of the player bullet and alien-grid/shield renderers in the pixel pipeline.
- Watches per-pixel drawing flags during active video and detects bullet/alien and bullet/shield overlap.
- Reports one kill per frame to the alien grid over a valid/ready handshake and maintains the score.
- Drives the bullet's reset, held across the next frame edge so the frame-clocked bullet samples it.

Parameters:
- SCREEN_CORDW, 16, width of screen coordinates.
- ALIEN_COLW, 4, width of alien column index.
- ALIEN_ROWW, 3, width of alien row index.
- SCORE_W, 16, score register width.
- POINTS, 10, score added per confirmed kill.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous, active-high reset.
- frame  in  1  one-clk pulse at start of vertical blanking.
- game_active  in  1  detection enable; low = overlaps ignored.
- screen_x  in  SCREEN_CORDW  current pixel x.
- screen_y  in  SCREEN_CORDW  current pixel y.
- bullet_drawing  in  1  bullet sprite covers current pixel.
- alien_drawing  in  1  a live alien covers current pixel.
- alien_col  in  ALIEN_COLW  column of the alien under the current pixel; valid when alien_drawing.
- alien_row  in  ALIEN_ROWW  row of the alien under the current pixel; valid when alien_drawing.
- shield_drawing  in  1  shield covers current pixel.
- kill_ready  in  1  alien grid accepts kill.
- kill_valid  out  1  kill request pending.
- kill_col  out  ALIEN_COLW  column of the killed alien.
- kill_row  out  ALIEN_ROWW  row of the killed alien.
- hit_x  out  SCREEN_CORDW  pixel x of first overlap, for the explosion effect.
- hit_y  out  SCREEN_CORDW  pixel y of first overlap.
- bullet_rst  out  1  reset to the bullet block.
- score  out  SCORE_W  accumulated score.

Behaviour:
- Reset (async, active-high): state SCAN; all outputs 0; internal hit flags cleared.
- All outputs are registered.
- SCAN:
  - On a clk where frame=0, game_active=1, bullet_drawing=1, and no hit is latched yet this frame:
    - if alien_drawing=1: latch alien hit, alien_col/row, screen_x/y;
    - else if shield_drawing=1: latch shield hit, screen_x/y.
  - Alien takes priority over shield on the same pixel.
  - After the first latch, all further overlaps in the frame are ignored (first hit in raster order wins).
  - On frame=1, using only flags latched before this cycle; any overlap in the frame cycle is ignored:
    - alien hit -> REPORT;
    - shield hit -> CLEAR;
    - no hit -> stay in SCAN.
  - In all three cases the hit flags are cleared.
- REPORT:
  - kill_valid=1; kill_col, kill_row, hit_x, hit_y held stable.
  - On a clk with kill_ready=1: transfer completes; score += POINTS, saturating at 2^SCORE_W-1; kill_valid drops the next cycle; go to CLEAR.
  - frame pulses while waiting are ignored; bullet_rst stays 0.
  - All overlaps are ignored.
- CLEAR:
  - bullet_rst=1; overlaps ignored.
  - Leaves to SCAN on the clk edge that samples frame=1, so bullet_rst is high throughout the frame-high cycle and drops one cycle after.
  - If CLEAR is entered on a frame cycle, that same pulse does not count; exit waits for the next frame pulse.
- game_active=0: no new latching; states REPORT and CLEAR complete normally.
- A shield hit produces no kill_valid and leaves score unchanged.
- Reset mid-REPORT or mid-CLEAR: request abandoned; no score change; bullet_rst=0 immediately.
- Latency: overlap to kill_valid = the cycle after the following frame pulse.

Test Plan:
- Overlap at (100,200), alien col 3 row 1, then frame, kill_ready=1 -> kill_valid next cycle with col 3, row 1, hit_x=100, hit_y=200; score 0->10; bullet_rst high until the cycle after the next frame pulse.
- Two overlaps in one frame (col 2 row 0, then col 5 row 4) -> single kill reporting col 2 row 0; second overlap ignored.
- Shield-only overlap at (40,300), then frame -> bullet_rst asserted across next frame edge; kill_valid never 1; score stays 0.
- kill_ready held 0 for 3 frame pulses with overlaps injected -> kill_valid and its fields stable; bullet_rst 0; on kill_ready=1 exactly one score increment.
- SCORE_W=5, POINTS=10, four kills -> score 10, 20, 30, 31 (saturation).
- rst pulsed while in REPORT -> kill_valid, bullet_rst, score all 0 asynchronously; a new overlap plus frame is reported normally afterwards.
